// File: rtl/pool2x2_stream_engine.sv
// Streaming 2x2 stride-2 max/average pooling of a raster-order signed feature map.
// Two-stage pipeline: result on valid_out 2 cycles after the window's last pixel; a stalled output freezes the whole pipe.
module pool2x2_stream_engine #(
  parameter  int DATA_W     = 8,
  parameter  int MAP_WIDTH  = 28,
  parameter  int MAP_HEIGHT = 28,
  localparam int OUT_W      = MAP_WIDTH / 2,
  localparam int OUT_H      = MAP_HEIGHT / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     mode_avg,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic signed [DATA_W-1:0] pixel_in,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic signed [DATA_W-1:0] pixel_out,
  output logic                     frame_done
);

  localparam int CW        = $clog2(MAP_WIDTH);
  localparam int RW        = $clog2(MAP_HEIGHT);
  localparam int OUT_TOTAL = OUT_W * OUT_H;
  localparam int OCW       = (OUT_TOTAL > 1) ? $clog2(OUT_TOTAL) : 1;

  localparam logic [CW-1:0]  COL_LAST     = CW'(MAP_WIDTH - 1);
  localparam logic [CW-1:0]  COL_TRIG_MAX = CW'(2 * OUT_W - 1);
  localparam logic [RW-1:0]  ROW_LAST     = RW'(MAP_HEIGHT - 1);
  localparam logic [RW-1:0]  ROW_TRIG_MAX = RW'(2 * OUT_H - 1);
  localparam logic [OCW-1:0] OUT_LAST     = OCW'(OUT_TOTAL - 1);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [OCW-1:0] out_cnt;
  logic           mode_q;

  logic signed [DATA_W-1:0] line_buf [MAP_WIDTH];
  logic signed [DATA_W-1:0] prev_pix;
  logic signed [DATA_W-1:0] prev_top;

  logic                     s1_valid;
  logic                     s1_mode;
  logic signed [DATA_W:0]   s1_top;
  logic signed [DATA_W:0]   s1_bot;
  logic                     out_vld_q;

  logic advance;
  logic accept;
  logic first_pix;
  logic trigger;
  logic out_fire;

  assign advance    = !out_vld_q || ready_out;
  assign ready_in   = advance && !clear;
  assign accept     = valid_in && ready_in;
  assign first_pix  = (col == '0) && (row == '0);
  assign trigger    = accept && col[0] && row[0] &&
                      (col <= COL_TRIG_MAX) && (row <= ROW_TRIG_MAX);
  assign valid_out  = out_vld_q && !clear;
  assign out_fire   = valid_out && ready_out;
  assign frame_done = out_fire && (out_cnt == OUT_LAST);

  // Window corners; line_buf[col] still holds the previous row until this accept writes it.
  logic signed [DATA_W-1:0] win_tl;
  logic signed [DATA_W-1:0] win_tr;
  logic signed [DATA_W-1:0] win_bl;
  logic signed [DATA_W-1:0] win_br;

  assign win_tl = prev_top;
  assign win_tr = line_buf[col];
  assign win_bl = prev_pix;
  assign win_br = pixel_in;

  logic signed [DATA_W-1:0] top_max;
  logic signed [DATA_W-1:0] bot_max;
  logic signed [DATA_W:0]   top_sum;
  logic signed [DATA_W:0]   bot_sum;
  logic signed [DATA_W:0]   s1_top_d;
  logic signed [DATA_W:0]   s1_bot_d;

  always_comb begin
    top_max  = (win_tl > win_tr) ? win_tl : win_tr;
    bot_max  = (win_bl > win_br) ? win_bl : win_br;
    top_sum  = (DATA_W+1)'(win_tl) + (DATA_W+1)'(win_tr);
    bot_sum  = (DATA_W+1)'(win_bl) + (DATA_W+1)'(win_br);
    s1_top_d = mode_q ? top_sum : (DATA_W+1)'(top_max);
    s1_bot_d = mode_q ? bot_sum : (DATA_W+1)'(bot_max);
  end

  // Average of four DATA_W values always fits DATA_W, so dropping the two LSBs is an exact floor.
  logic signed [DATA_W+1:0] pair_sum;
  logic signed [DATA_W:0]   pair_max;
  logic signed [DATA_W-1:0] s2_res;
  logic                     unused_bits;

  always_comb begin
    pair_sum = (DATA_W+2)'(s1_top) + (DATA_W+2)'(s1_bot);
    pair_max = (s1_top > s1_bot) ? s1_top : s1_bot;
    s2_res   = s1_mode ? pair_sum[DATA_W+1:2] : pair_max[DATA_W-1:0];
  end

  assign unused_bits = ^{pair_sum[1:0], pair_max[DATA_W]};

  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      mode_q   <= 1'b0;
      prev_pix <= '0;
      prev_top <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      prev_pix <= pixel_in;
      prev_top <= win_tr;
      if (first_pix) begin
        mode_q <= mode_avg;
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // The mode travels with each window so a new frame can start while the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_top    <= '0;
      s1_bot    <= '0;
      out_vld_q <= 1'b0;
      pixel_out <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (advance) begin
      s1_valid  <= trigger;
      out_vld_q <= s1_valid;
      if (trigger) begin
        s1_top  <= s1_top_d;
        s1_bot  <= s1_bot_d;
        s1_mode <= mode_q;
      end
      if (s1_valid) begin
        pixel_out <= s2_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (clear) begin
      out_cnt <= '0;
    end else if (out_fire) begin
      out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream_engine.sv
// Bench for pool2x2_stream_engine: 4x4, 5x5 and 28x28 instances driven one at a time
// and compared against a window-level arithmetic model of the pooling.
module tb_pool2x2_stream_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic clr [3];
  logic mode [3];
  logic vin [3];
  logic rdy [3];
  logic signed [7:0] pin [3];

  logic rin [3];
  logic vout [3];
  logic fdone [3];
  logic signed [7:0] pout [3];

  logic rin0, rin1, rin2, vout0, vout1, vout2, fd0, fd1, fd2;
  logic signed [7:0] pout0, pout1, pout2;

  int cyc = 0;
  int asserts = 0;
  int fails = 0;
  int rdy_bad = 0;
  int stab_bad = 0;

  int stim[$];
  int exp_q[$];
  int exp_trig[$];
  int exp_fd[$];
  int got[$];
  int got_cyc[$];
  int acc_cyc[$];
  int fd_pos[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rin[0] = rin0;   rin[1] = rin1;   rin[2] = rin2;
    vout[0] = vout0; vout[1] = vout1; vout[2] = vout2;
    fdone[0] = fd0;  fdone[1] = fd1;  fdone[2] = fd2;
    pout[0] = pout0; pout[1] = pout1; pout[2] = pout2;
  end

  pool2x2_stream_engine #(.DATA_W(8), .MAP_WIDTH(4), .MAP_HEIGHT(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .mode_avg(mode[0]),
    .valid_in(vin[0]), .ready_in(rin0), .pixel_in(pin[0]),
    .valid_out(vout0), .ready_out(rdy[0]), .pixel_out(pout0), .frame_done(fd0));

  pool2x2_stream_engine #(.DATA_W(8), .MAP_WIDTH(5), .MAP_HEIGHT(5)) u_p5 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .mode_avg(mode[1]),
    .valid_in(vin[1]), .ready_in(rin1), .pixel_in(pin[1]),
    .valid_out(vout1), .ready_out(rdy[1]), .pixel_out(pout1), .frame_done(fd1));

  pool2x2_stream_engine #(.DATA_W(8), .MAP_WIDTH(28), .MAP_HEIGHT(28)) u_p28 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .mode_avg(mode[2]),
    .valid_in(vin[2]), .ready_in(rin2), .pixel_in(pin[2]),
    .valid_out(vout2), .ready_out(rdy[2]), .pixel_out(pout2), .frame_done(fd2));

  // Reference: every 2x2 block of the frame at stim[off..], floor division for the average.
  function automatic void model(input int off, input int w, input int h, input int m);
    for (int oy = 0; oy < h / 2; oy++) begin
      for (int ox = 0; ox < w / 2; ox++) begin
        int i0, a, b, c, d, s, r;
        i0 = off + 2 * oy * w + 2 * ox;
        a = stim[i0]; b = stim[i0 + 1]; c = stim[i0 + w]; d = stim[i0 + w + 1];
        if (m != 0) begin
          s = a + b + c + d;
          r = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        end else begin
          r = a;
          if (b > r) r = b;
          if (c > r) r = c;
          if (d > r) r = d;
        end
        exp_q.push_back(r);
        exp_trig.push_back(i0 + w + 1);
      end
    end
    exp_fd.push_back(exp_q.size() - 1);
  endfunction

  task automatic reset_results();
    exp_q.delete(); exp_trig.delete(); exp_fd.delete();
    got.delete(); got_cyc.delete(); acc_cyc.delete(); fd_pos.delete();
    rdy_bad = 0;
    stab_bad = 0;
  endtask

  // Streams stim into instance u, logging accepts, outputs and frame_done pulses.
  task automatic drive(input int u, input int rdy_pct, input int m0, input int flip_at,
                       input int max_cyc);
    int idx;
    int tail;
    bit prev_stall;
    logic signed [7:0] prev_p;
    idx = 0; tail = 0; prev_stall = 0; prev_p = '0;
    for (int c = 0; c < max_cyc && tail < 4; c++) begin
      @(negedge clk);
      vin[u] = (idx < stim.size());
      if (idx < stim.size()) pin[u] = 8'(stim[idx]);
      else pin[u] = '0;
      if (flip_at >= 0 && idx >= flip_at) mode[u] = (m0 == 0);
      else mode[u] = (m0 != 0);
      rdy[u] = ($urandom_range(99) < rdy_pct);
      #1;
      if (rin[u] !== !(vout[u] && !rdy[u])) rdy_bad++;
      if (prev_stall && (vout[u] !== 1'b1 || pout[u] !== prev_p)) stab_bad++;
      prev_stall = vout[u] && !rdy[u];
      prev_p = pout[u];
      if (vout[u] && rdy[u]) begin
        got.push_back(int'(pout[u]));
        got_cyc.push_back(cyc);
      end
      if (fdone[u]) fd_pos.push_back((vout[u] && rdy[u]) ? got.size() - 1 : -1);
      if (vin[u] && rin[u]) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (idx >= stim.size() && got.size() >= exp_q.size()) tail++;
    end
    @(negedge clk);
    vin[u] = 1'b0;
    rdy[u] = 1'b1;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      asserts++;
      if (vout[u] !== 1'b0 || fdone[u] !== 1'b0 || pout[u] !== 8'sd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d]: valid_out=%b frame_done=%b pixel_out=%0d, want 0/0/0",
                 u, vout[u], fdone[u], pout[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      asserts++;
      if (rin[u] !== 1'b1) begin
        fails++;
        $display("FAIL reset_ready_in[%0d]: got %b, want 1", u, rin[u]);
      end
    end
  endtask

  task automatic test_4x4_modes();
    int want[4];
    for (int m = 0; m < 2; m++) begin
      if (m == 0) want = '{5, 7, 13, 15};
      else want = '{2, 4, 10, 12};
      reset_results();
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(i);
      model(0, 4, 4, m);
      drive(0, 100, m, -1, 200);
      asserts++;
      if (got.size() !== 4) begin
        fails++;
        $display("FAIL ramp4 mode%0d count: got %0d, want 4", m, got.size());
      end
      for (int k = 0; k < 4 && k < got.size(); k++) begin
        asserts++;
        if (got[k] !== want[k]) begin
          fails++;
          $display("FAIL ramp4 mode%0d value[%0d]: got %0d, want %0d", m, k, got[k], want[k]);
        end
        asserts++;
        if (exp_trig[k] >= acc_cyc.size() || got_cyc[k] !== acc_cyc[exp_trig[k]] + 2) begin
          fails++;
          $display("FAIL ramp4 mode%0d latency[%0d]: output cycle %0d, trigger pixel %0d",
                   m, k, got_cyc[k], exp_trig[k]);
        end
      end
      asserts++;
      if (fd_pos.size() !== 1 || fd_pos[0] !== 3) begin
        fails++;
        $display("FAIL ramp4 mode%0d frame_done: %0d pulses, first at output %0d, want 1 at 3",
                 m, fd_pos.size(), (fd_pos.size() > 0) ? fd_pos[0] : -99);
      end
    end
  endtask

  task automatic test_extreme_windows();
    int want0;
    for (int m = 0; m < 2; m++) begin
      reset_results();
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(255)) - 128);
      stim[0] = -1; stim[1] = -2; stim[4] = -3; stim[5] = -4;
      stim[2] = -128; stim[3] = -128; stim[6] = -128; stim[7] = -128;
      stim[8] = 127; stim[9] = 127; stim[12] = 127; stim[13] = 127;
      model(0, 4, 4, m);
      drive(0, 100, m, -1, 200);
      want0 = (m != 0) ? -3 : -1;
      asserts++;
      if (got.size() !== exp_q.size()) begin
        fails++;
        $display("FAIL extreme mode%0d count: got %0d, want %0d", m, got.size(), exp_q.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        asserts++;
        if (got[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL extreme mode%0d value[%0d]: got %0d, want %0d", m, k, got[k], exp_q[k]);
        end
      end
      if (got.size() >= 3) begin
        asserts++;
        if (got[0] !== want0 || got[1] !== -128 || got[2] !== 127) begin
          fails++;
          $display("FAIL extreme mode%0d corners: got %0d %0d %0d, want %0d -128 127",
                   m, got[0], got[1], got[2], want0);
        end
      end
    end
  endtask

  task automatic test_odd_5x5();
    reset_results();
    stim.delete();
    for (int i = 0; i < 25; i++) stim.push_back(i);
    model(0, 5, 5, 0);
    drive(1, 100, 0, -1, 200);
    asserts++;
    if (got.size() !== 4) begin
      fails++;
      $display("FAIL odd5 count: got %0d, want 4", got.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      asserts++;
      if (got[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL odd5 value[%0d]: got %0d, want %0d", k, got[k], exp_q[k]);
      end
      asserts++;
      if (exp_trig[k] >= acc_cyc.size() || got_cyc[k] !== acc_cyc[exp_trig[k]] + 2) begin
        fails++;
        $display("FAIL odd5 latency[%0d]: output cycle %0d, trigger pixel %0d",
                 k, got_cyc[k], exp_trig[k]);
      end
    end
    asserts++;
    if (fd_pos.size() !== 1 || fd_pos[0] !== 3) begin
      fails++;
      $display("FAIL odd5 frame_done: %0d pulses, first at %0d, want 1 at 3",
               fd_pos.size(), (fd_pos.size() > 0) ? fd_pos[0] : -99);
    end
  endtask

  task automatic test_random_28();
    for (int m = 0; m < 2; m++) begin
      reset_results();
      stim.delete();
      for (int i = 0; i < 784; i++) stim.push_back(int'($urandom_range(255)) - 128);
      model(0, 28, 28, m);
      drive(2, 60, m, -1, 6000);
      asserts++;
      if (got.size() !== 196) begin
        fails++;
        $display("FAIL rand28 mode%0d count: got %0d, want 196", m, got.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        asserts++;
        if (got[k] !== exp_q[k]) begin
          fails++;
          $display("FAIL rand28 mode%0d value[%0d]: got %0d, want %0d", m, k, got[k], exp_q[k]);
        end
      end
      asserts++;
      if (rdy_bad !== 0) begin
        fails++;
        $display("FAIL rand28 mode%0d ready_in rule: %0d bad cycles, want 0", m, rdy_bad);
      end
      asserts++;
      if (stab_bad !== 0) begin
        fails++;
        $display("FAIL rand28 mode%0d stall hold: %0d unstable cycles, want 0", m, stab_bad);
      end
      asserts++;
      if (fd_pos.size() !== 1 || fd_pos[0] !== 195) begin
        fails++;
        $display("FAIL rand28 mode%0d frame_done: %0d pulses, first at %0d, want 1 at 195",
                 m, fd_pos.size(), (fd_pos.size() > 0) ? fd_pos[0] : -99);
      end
    end
  endtask

  task automatic test_mode_latch_back_to_back();
    reset_results();
    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(int'($urandom_range(255)) - 128);
    model(0, 4, 4, 0);
    model(16, 4, 4, 1);
    drive(0, 100, 0, 7, 300);
    asserts++;
    if (got.size() !== 8) begin
      fails++;
      $display("FAIL b2b count: got %0d, want 8", got.size());
    end
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
      asserts++;
      if (got[k] !== exp_q[k]) begin
        fails++;
        $display("FAIL b2b value[%0d]: got %0d, want %0d", k, got[k], exp_q[k]);
      end
      asserts++;
      if (exp_trig[k] >= acc_cyc.size() || got_cyc[k] !== acc_cyc[exp_trig[k]] + 2) begin
        fails++;
        $display("FAIL b2b latency[%0d]: output cycle %0d, trigger pixel %0d",
                 k, got_cyc[k], exp_trig[k]);
      end
    end
    asserts++;
    if (acc_cyc.size() < 17 || acc_cyc[16] !== acc_cyc[15] + 1) begin
      fails++;
      $display("FAIL b2b gap: %0d pixels accepted, frame boundary not back-to-back", acc_cyc.size());
    end
    asserts++;
    if (fd_pos.size() !== 2 || fd_pos[0] !== 3 || fd_pos[1] !== 7) begin
      fails++;
      $display("FAIL b2b frame_done: %0d pulses, want 2 at outputs 3 and 7", fd_pos.size());
    end
  endtask

  task automatic test_reset_and_clear();
    int want[4];
    want = '{5, 7, 13, 15};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      vin[0] = 1'b1; pin[0] = 8'(i); rdy[0] = 1'b1; mode[0] = 1'b0;
    end
    @(negedge clk);
    vin[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    asserts++;
    if (vout[0] !== 1'b0 || fdone[0] !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset: valid_out=%b frame_done=%b, want 0/0", vout[0], fdone[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vin[0] = 1'b1; pin[0] = 8'(i); rdy[0] = 1'b1;
    end
    @(negedge clk);
    pin[0] = 8'sd6;
    clr[0] = 1'b1;
    #1;
    asserts++;
    if (rin[0] !== 1'b0 || vout[0] !== 1'b0) begin
      fails++;
      $display("FAIL clear_cycle: ready_in=%b valid_out=%b, want 0/0", rin[0], vout[0]);
    end
    @(negedge clk);
    clr[0] = 1'b0;
    vin[0] = 1'b0;
    #1;
    asserts++;
    if (vout[0] !== 1'b0) begin
      fails++;
      $display("FAIL after_clear: valid_out=%b, want 0", vout[0]);
    end
    @(negedge clk);
    #1;
    asserts++;
    if (vout[0] !== 1'b0) begin
      fails++;
      $display("FAIL inflight_discard: valid_out=%b, want 0", vout[0]);
    end
    reset_results();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(i);
    model(0, 4, 4, 0);
    drive(0, 100, 0, -1, 200);
    asserts++;
    if (got.size() !== 4) begin
      fails++;
      $display("FAIL restart count: got %0d, want 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      asserts++;
      if (got[k] !== want[k]) begin
        fails++;
        $display("FAIL restart value[%0d]: got %0d, want %0d", k, got[k], want[k]);
      end
    end
    asserts++;
    if (fd_pos.size() !== 1 || fd_pos[0] !== 3) begin
      fails++;
      $display("FAIL restart frame_done: %0d pulses, want 1 at output 3", fd_pos.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 3; u++) begin
      clr[u] = 1'b0; mode[u] = 1'b0; vin[u] = 1'b0; rdy[u] = 1'b1; pin[u] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    test_4x4_modes();
    test_extreme_windows();
    test_odd_5x5();
    test_random_28();
    test_mode_latch_back_to_back();
    test_reset_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
